// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. Converts one input bit per
// clock behind a start/busy/done handshake and holds the last result on bcd_out.
module bin_to_bcd_seq #(
  parameter int WIDTH      = 16,
  parameter int DIGITS     = 5,
  parameter int START_EDGE = 1
) (
  input  logic                  clk,
  input  logic                  rst_a_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_bin_sr;
  logic [BCD_W-1:0]   r_bcd_sr;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_done;
  logic               r_valid;
  logic               w_req;

  // A held level must yield a single request; the history flop resets to 0 so
  // a level already high at reset release still counts as a rising edge.
  if (START_EDGE != 0) begin : g_edge
    logic r_start_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) r_start_q <= 1'b0;
      else          r_start_q <= start;
    end

    assign w_req = start & ~r_start_q;
  end else begin : g_pulse
    assign w_req = start;
  end

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves the
    // output unassigned, which would otherwise infer a latch.
    w_bcd_adj = r_bcd_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd_sr[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd_sr[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_next_state = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_bin_sr  <= '0;
      r_bcd_sr  <= '0;
      r_cnt     <= '0;
      r_bcd_out <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_bin_sr <= bin_in;
            r_bcd_sr <= '0;
            r_cnt    <= CNT_W'(WIDTH);
          end
        end
        S_SHIFT: begin
          {r_bcd_sr, r_bin_sr} <= {w_bcd_adj, r_bin_sr} << 1;
          r_cnt                <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          // bcd_out only changes here, so it never exposes partial results.
          r_bcd_out <= r_bcd_sr;
          r_done    <= 1'b1;
          r_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign valid   = r_valid;
  assign bcd_out = r_bcd_out;

endmodule
